// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register: single-cycle ADD/SUB/AND/OR and an
// iterative shift-add multiplier that back-pressures upstream through stall_o.
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] val1_i,
  input  logic [XLEN-1:0] val2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [3:0]      ALUCtrl_i,
  input  logic            ALUSrc_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [1:0]      Mem_i,
  input  logic            WB_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [4:0]      rd_addr_o,
  output logic [1:0]      Mem_o,
  output logic            WB_o
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic [1:0]      mem;
    logic            wb;
  } exmem_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  exmem_t          exmem_q, exmem_d;

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            mul_req;

  assign op_b    = ALUSrc_i ? imm_i : val2_i;
  assign mul_req = valid_i && (ALUCtrl_i == OP_MUL);

  // Single-cycle ALU; unknown codes fall back to add.
  always_comb begin
    case (ALUCtrl_i)
      OP_SUB:  alu_res = val1_i - op_b;
      OP_AND:  alu_res = val1_i & op_b;
      OP_OR:   alu_res = val1_i | op_b;
      OP_ADD:  alu_res = val1_i + op_b;
      default: alu_res = val1_i + op_b;
    endcase
  end

  // Gated by reset so upstream is released the moment reset asserts.
  assign stall_o = rst_i && (((state_q == IDLE) && mul_req) || (state_q == BUSY));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      exmem_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      exmem_q  <= exmem_d;
    end
  end

  // Next-state, multiplier datapath and EX/MEM load; bubble unless a result is ready.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    exmem_d  = '0;
    case (state_q)
      IDLE: begin
        if (mul_req) begin
          mcand_d  = val1_i;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end else if (valid_i) begin
          exmem_d.valid  = 1'b1;
          exmem_d.result = alu_res;
          exmem_d.wdata  = val2_i;
          exmem_d.rd     = rd_addr_i;
          exmem_d.mem    = Mem_i;
          exmem_d.wb     = WB_i;
        end
      end
      BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Upstream is still holding the MUL instruction's control fields.
        exmem_d.valid  = 1'b1;
        exmem_d.result = acc_q;
        exmem_d.wdata  = val2_i;
        exmem_d.rd     = rd_addr_i;
        exmem_d.mem    = Mem_i;
        exmem_d.wb     = WB_i;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid_o      = exmem_q.valid;
  assign alu_result_o = exmem_q.result;
  assign wdata_o      = exmem_q.wdata;
  assign rd_addr_o    = exmem_q.rd;
  assign Mem_o        = exmem_q.mem;
  assign WB_o         = exmem_q.wb;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes expected EX/MEM contents, monitor pops on valid_o.
module tb_ex_stage;

  localparam int unsigned XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic [XLEN-1:0] val1_i, val2_i, imm_i;
  logic [3:0]      ALUCtrl_i;
  logic            ALUSrc_i;
  logic [4:0]      rd_addr_i;
  logic [1:0]      Mem_i;
  logic            WB_i;
  logic            stall_o;
  logic            valid_o;
  logic [XLEN-1:0] alu_result_o, wdata_o;
  logic [4:0]      rd_addr_o;
  logic [1:0]      Mem_o;
  logic            WB_o;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic [1:0]      mem;
    logic            wb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  ex_stage #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .val1_i(val1_i), .val2_i(val2_i), .imm_i(imm_i),
    .ALUCtrl_i(ALUCtrl_i), .ALUSrc_i(ALUSrc_i), .rd_addr_i(rd_addr_i),
    .Mem_i(Mem_i), .WB_i(WB_i), .stall_o(stall_o), .valid_o(valid_o),
    .alu_result_o(alu_result_o), .wdata_o(wdata_o), .rd_addr_o(rd_addr_o),
    .Mem_o(Mem_o), .WB_o(WB_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    n_cmp++;
    if (valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result got=%h rd=%0d", alu_result_o, rd_addr_o);
      end else begin
        e = sb.pop_front();
        if (alu_result_o !== e.result || wdata_o !== e.wdata || rd_addr_o !== e.rd ||
            Mem_o !== e.mem || WB_o !== e.wb) begin
          n_fail++;
          $display("FAIL result got res=%h wd=%h rd=%0d mem=%b wb=%b exp res=%h wd=%h rd=%0d mem=%b wb=%b",
                   alu_result_o, wdata_o, rd_addr_o, Mem_o, WB_o,
                   e.result, e.wdata, e.rd, e.mem, e.wb);
        end
      end
    end else if (valid_o !== 1'b0 || WB_o !== 1'b0 || Mem_o !== 2'b00) begin
      n_fail++;
      $display("FAIL bubble got valid=%b wb=%b mem=%b exp 0 0 00", valid_o, WB_o, Mem_o);
    end
  end

  task automatic drive(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] im, input logic [3:0] code, input logic src,
                       input logic [4:0] rd, input logic [1:0] mem, input logic wb);
    valid_i = v; val1_i = a; val2_i = b; imm_i = im;
    ALUCtrl_i = code; ALUSrc_i = src; rd_addr_i = rd; Mem_i = mem; WB_i = wb;
  endtask

  task automatic issue_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] im, input logic [3:0] code, input logic src,
                           input logic [4:0] rd, input logic [1:0] mem, input logic wb,
                           input logic [XLEN-1:0] exp_res);
    @(negedge clk_i);
    drive(1'b1, a, b, im, code, src, rd, mem, wb);
    sb.push_back('{result: exp_res, wdata: b, rd: rd, mem: mem, wb: wb});
    #1;
    chk("alu_no_stall", XLEN'(stall_o), '0);
  endtask

  task automatic issue_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] im, input logic src,
                           input logic [4:0] rd, input logic [1:0] mem, input logic wb,
                           input logic [XLEN-1:0] exp_res);
    int cnt = 0;
    @(negedge clk_i);
    drive(1'b1, a, b, im, 4'b1111, src, rd, mem, wb);
    sb.push_back('{result: exp_res, wdata: b, rd: rd, mem: mem, wb: wb});
    #1;
    while (stall_o === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk_i);
      #1;
    end
    chk("mul_stall_cycles", XLEN'(cnt), XLEN'(XLEN + 1));
    @(posedge clk_i);
    #1;
    chk("mul_valid_after_stall", XLEN'(valid_o), XLEN'(1));
  endtask

  task automatic idle(input int n);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (n - 1) @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b0;
    drive(1'b0, '0, '0, '0, 4'b0010, 1'b0, 5'd0, 2'b00, 1'b0);
    repeat (2) @(negedge clk_i);
    chk("rst_stall", XLEN'(stall_o), '0);
    chk("rst_valid", XLEN'(valid_o), '0);
    chk("rst_result", alu_result_o, '0);
    chk("rst_wdata", wdata_o, '0);
    chk("rst_rd", XLEN'(rd_addr_o), '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    idle(2);

    // add with wrap, then imm-sourced AND/OR/SUB back to back, undefined code as add
    issue_alu(32'hFFFF_FFFF, 32'h2, 32'h0, 4'b0010, 1'b0, 5'd5, 2'b00, 1'b1, 32'h0000_0001);
    issue_alu(32'hF0F0_F0F0, 32'h0, 32'h0FF0, 4'b0000, 1'b1, 5'd6, 2'b00, 1'b1, 32'h0000_00F0);
    issue_alu(32'hF0F0_F0F0, 32'h0, 32'h0FF0, 4'b0001, 1'b1, 5'd7, 2'b00, 1'b1, 32'hF0F0_FFF0);
    issue_alu(32'hF0F0_F0F0, 32'h0, 32'h0FF0, 4'b0110, 1'b1, 5'd8, 2'b00, 1'b1, 32'hF0F0_E100);
    issue_alu(32'd10, 32'd20, 32'h0, 4'b0111, 1'b0, 5'd9, 2'b00, 1'b1, 32'd30);
    idle(2);

    // MUL 7x6, then MUL wrap followed immediately by add
    issue_mul(32'd7, 32'd6, 32'h0, 1'b0, 5'd10, 2'b00, 1'b1, 32'd42);
    issue_mul(32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0, 5'd11, 2'b00, 1'b1, 32'hFFFF_FFFE);
    issue_alu(32'd1, 32'd1, 32'h0, 4'b0010, 1'b0, 5'd12, 2'b00, 1'b1, 32'd2);
    issue_mul(32'h1234_5678, 32'h0, 32'h100, 1'b1, 5'd13, 2'b10, 1'b1, 32'h3456_7800);

    // store passthrough
    issue_alu(32'h100, 32'hDEAD_BEEF, 32'h4, 4'b0010, 1'b1, 5'd14, 2'b01, 1'b0, 32'h104);
    idle(3);

    // reset mid-MUL: abandon, stall drops, nothing ever written
    @(negedge clk_i);
    drive(1'b1, 32'd5, 32'd3, 32'h0, 4'b1111, 1'b0, 5'd15, 2'b00, 1'b1);
    #1;
    chk("rmul_stall_on", XLEN'(stall_o), XLEN'(1));
    repeat (10) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rmul_stall", XLEN'(stall_o), '0);
    chk("rmul_valid", XLEN'(valid_o), '0);
    chk("rmul_result", alu_result_o, '0);
    chk("rmul_wdata", wdata_o, '0);
    chk("rmul_rd", XLEN'(rd_addr_o), '0);
    chk("rmul_wb", XLEN'(WB_o), '0);
    chk("rmul_mem", XLEN'(Mem_o), '0);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (40) @(negedge clk_i);
    chk("rmul_stall_after", XLEN'(stall_o), '0);
    chk("sb_drained", XLEN'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage and EX/MEM pipeline register, the downstream consumer of the ID/EX register outputs. It takes operand values, immediate, 4-bit ALU control code and the pipelined Mem/WB control fields, and computes the ALU result. ADD/SUB/AND/OR complete in one cycle; MUL runs on an iterative shift-add unit that back-pressures upstream stages via `stall_o`. Results and control fields are registered toward the MEM stage.

## Interface
- `XLEN`, 32: datapath width; MUL takes `XLEN` iteration cycles.
- `clk_i`  in  1  clock, all state updates on rising edge
- `rst_i`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  ID/EX holds a real instruction (0 = bubble)
- `val1_i`  in  XLEN  rs1 operand
- `val2_i`  in  XLEN  rs2 operand / store data
- `imm_i`  in  XLEN  sign-extended immediate
- `ALUCtrl_i`  in  4  0010 add, 0110 sub, 0000 and, 0001 or, 1111 mul
- `ALUSrc_i`  in  1  1 = operand B is `imm_i`, 0 = `val2_i`
- `rd_addr_i`  in  5  destination register
- `Mem_i`  in  2  memory control (passed through)
- `WB_i`  in  1  register-write enable (passed through)
- `stall_o`  out  1  combinational; 1 = hold ID/EX and earlier stages
- `valid_o`  out  1  EX/MEM holds a real instruction
- `alu_result_o`  out  XLEN  registered result
- `wdata_o`  out  XLEN  registered `val2_i` (store data)
- `rd_addr_o`  out  5  registered destination
- `Mem_o`  out  2  registered memory control
- `WB_o`  out  1  registered write enable

## Operation
- Operand A = `val1_i`; operand B = `ALUSrc_i ? imm_i : val2_i`.
- Add/sub are modulo 2^XLEN. AND/OR are bitwise. Any undefined code is treated as add.
- MUL result is the low XLEN bits of the unsigned product, equal to the low bits of the signed product.
- FSM states:
  - IDLE: default. If `valid_i` and code 1111, latch A as multiplicand and B as multiplier, clear accumulator and counter, go to BUSY.
  - BUSY: each edge, if multiplier bit0 is 1, add multiplicand into accumulator; then shift multiplicand left 1 and multiplier right 1, and increment the counter. After the XLEN-th iteration, go to DONE.
  - DONE: EX/MEM loads the accumulator as `alu_result_o`, plus the control fields of the held instruction. Go to IDLE.
- `stall_o` = (IDLE and `valid_i` and code 1111) or BUSY. It is 0 in DONE.
- While `stall_o` = 1, EX/MEM loads a bubble: `valid_o`, `WB_o`, `Mem_o` = 0. Other fields don't-care; drive them 0.
- With `valid_i` = 0 in IDLE, EX/MEM loads a bubble.
- Non-MUL valid instruction in IDLE: EX/MEM loads result, `val2_i`, `rd_addr_i`, `Mem_i`, `WB_i`, and `valid_o` = 1.
- Upstream holds its inputs stable whenever `stall_o` = 1. The inputs are not re-sampled during BUSY; the latched operands are authoritative.

## Timing
- Reset (`rst_i` low, asynchronous): FSM to IDLE; counter, accumulator and all registered outputs go to 0; `stall_o` = 0 while in reset.
- Non-MUL latency: inputs presented in cycle c appear on the outputs after the edge ending cycle c. Back-to-back issue is allowed, one per cycle.
- MUL presented in cycle c0:
  - `stall_o` = 1 for cycles c0 through c0+XLEN, which is XLEN+1 cycles.
  - Cycle c0+XLEN+1 is DONE, with `stall_o` = 0.
  - The result is visible after the edge ending c0+XLEN+1.
  - The next instruction is presented in c0+XLEN+2.
- Back-to-back MULs: the second enters IDLE-accept in the cycle after DONE. There is no extra gap beyond the above.
- Reset asserted mid-MUL: the operation is abandoned, no result is written, and `stall_o` drops immediately. After release the FSM is in IDLE and will re-accept whatever is on the inputs.
- Counter width is ceil(log2(XLEN))+1 bits; it must not wrap before DONE.

## Test plan
- Add with wrap: val1=0xFFFFFFFF, val2=0x2, ALUSrc=0, code 0010, WB=1, rd=5 -> next cycle alu_result_o=0x00000001, rd_addr_o=5, WB_o=1, valid_o=1, stall_o never high.
- Immediate and logic ops: val1=0xF0F0F0F0, imm=0x0FF0, ALUSrc=1 with codes 0000, 0001, 0110 on consecutive cycles -> results 0x000000F0, 0xF0F0FFF0, 0xF0F0E100 on three successive cycles.
- MUL 7×6 (XLEN=32): stall_o high exactly 33 cycles, bubbles (WB_o=0, Mem_o=0) during the stall, then alu_result_o=42 with valid_o=1 one cycle after stall_o falls.
- MUL wrap: 0xFFFFFFFF × 0x2 -> 0xFFFFFFFE. Then an immediately following add 1+1 -> 2 on the cycle after the MUL result.
- Store passthrough: Mem=2'b01, WB=0, val2=0xDEADBEEF, code 0010 -> wdata_o=0xDEADBEEF, Mem_o=2'b01, WB_o=0.
- Reset mid-MUL at iteration 10: all outputs 0 and stall_o=0 during reset. After release with valid_i=0, outputs remain bubbles and no result ever appears.
